// File: rtl/n64a_vinfo_ctrl_if.sv
// n64a_vinfo_ctrl_if: sync nibble, config and demux/status signals of the video-mode controller
interface n64a_vinfo_ctrl_if;
  logic       nVDSYNC;
  logic [3:0] vdata_sy_i;
  logic       cfg_deblur_i;
  logic       cfg_n15bit_i;
  logic [2:0] demuxparams_o;
  logic       palmode_o;
  logic       interlaced_o;
  logic       field_o;
  logic       stable_o;
  logic       nosync_o;
  modport master (
    output nVDSYNC, vdata_sy_i, cfg_deblur_i, cfg_n15bit_i,
    input  demuxparams_o, palmode_o, interlaced_o, field_o, stable_o, nosync_o
  );
  modport slave (
    input  nVDSYNC, vdata_sy_i, cfg_deblur_i, cfg_n15bit_i,
    output demuxparams_o, palmode_o, interlaced_o, field_o, stable_o, nosync_o
  );
endinterface

// File: rtl/n64a_vinfo_ctrl.sv
// n64a_vinfo_ctrl: classifies PAL/NTSC and progressive/interlaced from line counts
// and updates the demux parameters only at field boundaries.
module n64a_vinfo_ctrl #(
  parameter int LINECNT_W  = 10,
  parameter int PAL_THRESH = 288
) (
  input logic               VCLK,
  input logic               nRST,
  n64a_vinfo_ctrl_if.slave  vi
);
  localparam logic [LINECNT_W-1:0] LC_MAX = '1;
  localparam logic [LINECNT_W-1:0] PAL_T  = LINECNT_W'(PAL_THRESH);
  logic [3:0]           sy_prev;
  logic [LINECNT_W-1:0] line_cnt, last_cnt;
  logic                 hs_edge, vs_edge, pal_new, ilace_new, stable_new, deblur_en;
  always_comb begin
    hs_edge    = sy_prev[1] & ~vi.vdata_sy_i[1];
    vs_edge    = sy_prev[3] & ~vi.vdata_sy_i[3];
    pal_new    = line_cnt > PAL_T;
    ilace_new  = line_cnt != last_cnt;
    stable_new = (pal_new == vi.palmode_o) & (ilace_new == vi.interlaced_o);
    deblur_en  = vi.cfg_deblur_i & ~ilace_new & stable_new;
  end
  always_ff @(posedge VCLK or negedge nRST)
    if (!nRST) begin
      sy_prev          <= 4'hF;
      line_cnt         <= '0;
      last_cnt         <= '0;
      vi.demuxparams_o <= 3'b011;
      vi.palmode_o     <= 1'b0;
      vi.interlaced_o  <= 1'b0;
      vi.field_o       <= 1'b0;
      vi.stable_o      <= 1'b0;
      vi.nosync_o      <= 1'b0;
    end else if (!vi.nVDSYNC) begin
      sy_prev <= vi.vdata_sy_i;
      if (vs_edge) begin
        vi.palmode_o     <= pal_new;
        vi.interlaced_o  <= ilace_new;
        vi.stable_o      <= stable_new;
        vi.field_o       <= ilace_new & ~vi.field_o;
        vi.demuxparams_o <= {pal_new, ~deblur_en, vi.cfg_n15bit_i};
        vi.nosync_o      <= 1'b0;
        last_cnt         <= line_cnt;
        line_cnt         <= '0;
      end else if (hs_edge) begin
        // saturating count; reaching all-ones flags a missing vertical sync
        line_cnt    <= line_cnt + {{(LINECNT_W-1){1'b0}}, ~&line_cnt};
        vi.nosync_o <= vi.nosync_o | (line_cnt == LC_MAX - 1'b1);
      end
    end
endmodule

// File: tb/tb_n64a_vinfo_ctrl.sv
// tb_n64a_vinfo_ctrl: directed field sequences with hand-computed status vectors
// {demuxparams[2:0], palmode, interlaced, field, stable, nosync}.
module tb_n64a_vinfo_ctrl;
  logic VCLK = 1'b0;
  logic nRST = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  n64a_vinfo_ctrl_if vi ();
  n64a_vinfo_ctrl dut (.VCLK(VCLK), .nRST(nRST), .vi(vi));
  always #5 VCLK = ~VCLK;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [7:0] exp);
    chk(tag, {2'b00, vi.demuxparams_o, vi.palmode_o, vi.interlaced_o,
              vi.field_o, vi.stable_o, vi.nosync_o}, {2'b00, exp});
  endtask

  // one nVDSYNC-low sample followed by a cycle of junk that must be ignored
  task automatic sample(input logic [3:0] n);
    @(negedge VCLK);
    vi.nVDSYNC    = 1'b0;
    vi.vdata_sy_i = n;
    @(negedge VCLK);
    vi.nVDSYNC    = 1'b1;
    vi.vdata_sy_i = 4'h0;
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      sample(4'b1101);
      sample(4'b1111);
    end
  endtask

  task automatic field(input int n);
    lines(n);
    sample(4'b0111);
  endtask

  initial begin
    vi.nVDSYNC      = 1'b1;
    vi.vdata_sy_i   = 4'h0;
    vi.cfg_deblur_i = 1'b1;
    vi.cfg_n15bit_i = 1'b1;
    repeat (3) @(negedge VCLK);
    chk_st("reset", 8'b011_00000);
    nRST = 1'b1;
    field(263); chk_st("ntsc_f1", 8'b011_01100);
    field(263); chk_st("ntsc_f2", 8'b011_00000);
    field(263); chk_st("ntsc_f3", 8'b001_00010);
    field(263); chk_st("ntsc_f4", 8'b001_00010);
    field(312); chk_st("pal_f1", 8'b111_11100);
    field(313); chk_st("pal_f2", 8'b111_11010);
    field(312); chk_st("pal_f3", 8'b111_11110);
    field(313); chk_st("pal_f4", 8'b111_11010);
    field(263); chk_st("back_f1", 8'b011_01100);
    field(263); chk_st("back_f2", 8'b011_00000);
    field(263); chk_st("back_f3", 8'b001_00010);
    vi.cfg_deblur_i = 1'b0;
    field(263); chk_st("deblur_off", 8'b011_00010);
    vi.cfg_deblur_i = 1'b1;
    field(263); chk_st("deblur_on", 8'b001_00010);
    lines(131);
    vi.cfg_n15bit_i = 1'b0;
    lines(1);   chk_st("cfg_mid", 8'b001_00010);
    lines(131); chk_st("cfg_pre_vs", 8'b001_00010);
    sample(4'b0111); chk_st("cfg_at_vs", 8'b000_00010);
    vi.cfg_n15bit_i = 1'b1;
    field(263); chk_st("cfg_restore", 8'b001_00010);
    lines(1022); chk_st("nosync_1022", 8'b001_00010);
    lines(1);    chk_st("nosync_1023", 8'b001_00011);
    lines(77);   chk_st("nosync_1100", 8'b001_00011);
    sample(4'b0111); chk_st("nosync_clear", 8'b111_11100);
    field(263); chk_st("resync_f1", 8'b011_01000);
    field(263); chk_st("resync_f2", 8'b011_00000);
    lines(263);
    sample(4'b0101); chk_st("simul_vs", 8'b001_00010);
    chk("simul_cnt", {6'd0, dut.line_cnt[3:0]}, 10'd0);
    sample(4'b1111);
    field(263); chk_st("simul_next", 8'b001_00010);
    field(263); chk_st("simul_next2", 8'b001_00010);
    lines(100);
    @(negedge VCLK);
    #2 nRST = 1'b0;
    #1 chk_st("async_rst", 8'b011_00000);
    @(negedge VCLK);
    nRST = 1'b1;
    field(263); chk_st("rst_f1", 8'b011_01100);
    field(263); chk_st("rst_f2", 8'b011_00000);
    field(263); chk_st("rst_f3", 8'b001_00010);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/n64a_vinfo_ctrl.md
# n64a_vinfo_ctrl

Video-mode controller for the N64 input path. It watches the sync nibble that the demux captures on every nVDSYNC-low cycle and counts lines per field to classify PAL/NTSC and progressive/interlaced. It merges that result with user configuration and drives the 3-bit `demuxparams_o` bus consumed by the video demux. It sits between the configuration registers and the demux, and updates only at field boundaries so the demux never changes mode mid-frame.

## Interface

Parameters:

- `LINECNT_W`, 10, width of the line counter; saturates at all-ones.
- `PAL_THRESH`, 288, a field with more counted lines than this is PAL.

Ports. One clock; reset is asynchronous and active-low (`VCLK`, `nRST`).

- `VCLK`, in, 1, video clock.
- `nRST`, in, 1, async active-low reset.
- `nVDSYNC`, in, 1, low on the sync/control cycle of each 4-cycle pixel group.
- `vdata_sy_i`, in, 4, sync nibble `{nVSYNC, nCLAMP, nHSYNC, nCSYNC}`, valid when `nVDSYNC`=0.
- `cfg_deblur_i`, in, 1, user requests deblur.
- `cfg_n15bit_i`, in, 1, 1 = full 7-bit colour, 0 = 15-bit (5-bit) mode.
- `demuxparams_o`, out, 3, `{palmode, ndo_deblur, n15bit_mode}` to the demux.
- `palmode_o`, out, 1, current field classified PAL.
- `interlaced_o`, out, 1, interlaced content detected.
- `field_o`, out, 1, toggles every field while interlaced; 0 when progressive.
- `stable_o`, out, 1, last two fields had the same classification.
- `nosync_o`, out, 1, line counter saturated without a vertical sync.

## Operation

- Sampling: the block registers `vdata_sy_i` only on cycles with `nVDSYNC`=0, into `sy_prev`. All edges are computed between consecutive samples; other cycles are ignored.
- HSYNC edge: `sy_prev[1]`=1 and `vdata_sy_i[1]`=0. It increments `line_cnt`, which saturates at 2^LINECNT_W−1. Saturation sets `nosync_o`.
- VSYNC edge: `sy_prev[3]`=1 and `vdata_sy_i[3]`=0. This is the field boundary. On it the block performs, in one cycle:
  - `pal_new` = (`line_cnt` > PAL_THRESH).
  - `ilace_new` = (`line_cnt` ≠ `last_cnt`), i.e. field lengths differ.
  - `stable_o` = (`pal_new` == `palmode_o`) and (`ilace_new` == `interlaced_o`).
  - Update `palmode_o` and `interlaced_o`. `field_o` ← `ilace_new` ? ~`field_o` : 0.
  - `last_cnt` ← `line_cnt`; `line_cnt` ← 0; `nosync_o` ← 0.
  - `demuxparams_o` ← {`pal_new`, ~deblur_en, `cfg_n15bit_i`}.
  - `deblur_en` = `cfg_deblur_i` & ~`ilace_new` & `stable_new`, where `stable_new` is the value being written to `stable_o`.
- HSYNC and VSYNC edge in the same sample: the VSYNC action wins. The counter restarts at 0; the concurrent HSYNC is not counted.
- Config inputs are sampled only at the VSYNC edge. Changes mid-field have no effect until the next field.
- While `nosync_o`=1: `demuxparams_o` holds its value; status outputs hold.

## Timing

- Reset values: `demuxparams_o`=3'b011, `palmode_o`=0, `interlaced_o`=0, `field_o`=0, `stable_o`=0, `nosync_o`=0. Internal `line_cnt`=0, `last_cnt`=0, `sy_prev`=4'hF.
- Latency: outputs change on the VCLK edge that samples the VSYNC-falling nibble. They are visible one cycle later to the demux, which samples `demuxparams_o` on its next `nVDSYNC`-low cycle (≥3 cycles later).
- `demuxparams_o` changes only on VSYNC-edge cycles and never otherwise.
- Reset mid-field: everything returns to reset values immediately. The first VSYNC edge after reset compares against `last_cnt`=0, so it reports `interlaced_o`=1 and `stable_o`=0; a correct classification needs 2 fields.
- Deblur is enabled no earlier than the second field after a mode change, because `stable_new` is required.

## Test plan

- NTSC 240p: 263 HSYNC edges per field for 4 fields with `cfg_deblur_i`=1 and `cfg_n15bit_i`=1 → from field 3 on, `palmode_o`=0, `interlaced_o`=0, `stable_o`=1, `demuxparams_o`=3'b001.
- PAL 480i: alternate 312/313 lines → `palmode_o`=1, `interlaced_o`=1, `field_o` toggles each field, deblur forced off, `demuxparams_o`=3'b111 when `cfg_n15bit_i`=1.
- Config mid-field: in steady NTSC 240p, toggle `cfg_n15bit_i` 1→0 halfway through a field → `demuxparams_o[0]` stays 1 until the next VSYNC edge, then becomes 0 in that cycle.
- Sync loss: no VSYNC for 1100 lines → `nosync_o`=1 after line 1023 and `demuxparams_o` unchanged; the next VSYNC edge clears `nosync_o`.
- Simultaneous edges: HSYNC and VSYNC fall in the same sample → `line_cnt`=0 afterwards, and the next field's count excludes that edge.
- Async reset asserted mid-field with `demuxparams_o`=3'b001 → immediately 3'b011, all status outputs 0; re-classification completes after 2 fields.
